copro_batch_sequencer: RTL and testbench

Batch front-end for the fixed-point multiply-add coprocessor. It sits between the ZX-Uno register port and the MAC.
- Assembles host byte writes into operand triples (A, B, C), queues them, and issues them to the MAC one at a time.
- Captures each D result into a result queue that the host drains byte by byte.
- Lets the Z80 stream several operations without waiting on each result.

---
 rtl/copro_batch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_copro_batch_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/copro_batch_sequencer.sv
// Batch front-end for the fixed-point MAC: assembles host bytes into operand triples,
// issues them one at a time and queues 16-bit results for byte-wise host readout.
module copro_batch_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_stb,
    input  logic [7:0]  wr_data,
    input  logic        rd_stb,
    output logic [7:0]  rd_data,
    output logic [7:0]  status,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [15:0] mac_c,
    input  logic [15:0] mac_d
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StStore} state_e;

    state_e        r_state, w_state_d;
    logic [LW-1:0] r_lat_cnt;

    logic [7:0]    r_asm [5];
    logic [2:0]    r_byte_idx;
    logic          r_ovf;
    logic          r_half;

    logic [47:0]   r_op_mem [DEPTH];
    logic [AW-1:0] r_op_wptr, r_op_rptr;
    logic [CW-1:0] r_op_cnt;

    logic [15:0]   r_res_mem [DEPTH];
    logic [AW-1:0] r_res_wptr, r_res_rptr;
    logic [CW-1:0] r_res_cnt;

    logic          w_op_full, w_op_empty, w_res_empty;
    logic          w_asm_done, w_op_push, w_issue, w_store, w_rd_pop, w_busy;
    logic [47:0]   w_triple;
    logic [15:0]   w_res_head;

    assign w_op_full   = (r_op_cnt == CW'(DEPTH));
    assign w_op_empty  = (r_op_cnt == '0);
    assign w_res_empty = (r_res_cnt == '0);
    assign w_asm_done  = wr_stb && (r_byte_idx == 3'd5);
    assign w_op_push   = w_asm_done && !w_op_full && !clr;
    assign w_rd_pop    = rd_stb && !w_res_empty && r_half;
    assign w_triple    = {wr_data, r_asm[4], r_asm[3], r_asm[2], r_asm[1], r_asm[0]};
    assign w_res_head  = r_res_mem[r_res_rptr];
    assign w_busy      = (r_state != StIdle) || !w_op_empty;

    assign rd_data = w_res_empty ? 8'h00 : (r_half ? w_res_head[15:8] : w_res_head[7:0]);
    assign status  = {r_ovf, w_busy, w_op_full, w_res_empty, 4'(r_res_cnt)};

    // Issue only when the result FIFO can absorb the in-flight op as well.
    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_store   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_op_empty && (r_res_cnt < CW'(DEPTH))) begin
                    w_issue   = 1'b1;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (r_lat_cnt == LW'(MAC_LATENCY - 1)) begin
                    w_state_d = StStore;
                end
            end
            StStore: begin
                w_store   = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        if (clr) begin
            w_state_d = StIdle;
            w_issue   = 1'b0;
            w_store   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // MAC operands survive clr so the MAC inputs never glitch on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_a <= '0;
            mac_b <= '0;
            mac_c <= '0;
        end else if (w_issue) begin
            mac_a <= r_op_mem[r_op_rptr][15:0];
            mac_b <= r_op_mem[r_op_rptr][31:16];
            mac_c <= r_op_mem[r_op_rptr][47:32];
        end
    end

    always_ff @(posedge clk) begin
        if (w_op_push) begin
            r_op_mem[r_op_wptr] <= w_triple;
        end
        if (w_store) begin
            r_res_mem[r_res_wptr] <= mac_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) r_asm[i] <= '0;
            r_byte_idx <= '0;
            r_ovf      <= 1'b0;
            r_half     <= 1'b0;
            r_lat_cnt  <= '0;
            r_op_wptr  <= '0;
            r_op_rptr  <= '0;
            r_op_cnt   <= '0;
            r_res_wptr <= '0;
            r_res_rptr <= '0;
            r_res_cnt  <= '0;
        end else if (clr) begin
            for (int i = 0; i < 5; i++) r_asm[i] <= '0;
            r_byte_idx <= '0;
            r_ovf      <= 1'b0;
            r_half     <= 1'b0;
            r_lat_cnt  <= '0;
            r_op_wptr  <= '0;
            r_op_rptr  <= '0;
            r_op_cnt   <= '0;
            r_res_wptr <= '0;
            r_res_rptr <= '0;
            r_res_cnt  <= '0;
        end else begin
            if (wr_stb) begin
                if (r_byte_idx == 3'd5) begin
                    r_byte_idx <= '0;
                end else begin
                    r_asm[r_byte_idx] <= wr_data;
                    r_byte_idx        <= r_byte_idx + 3'd1;
                end
            end
            if (w_asm_done && w_op_full) begin
                r_ovf <= 1'b1;
            end

            if (w_issue) begin
                r_lat_cnt <= '0;
            end else if (r_state == StWait) begin
                r_lat_cnt <= r_lat_cnt + LW'(1);
            end

            if (w_op_push) r_op_wptr <= r_op_wptr + AW'(1);
            if (w_issue)   r_op_rptr <= r_op_rptr + AW'(1);
            unique case ({w_op_push, w_issue})
                2'b10:   r_op_cnt <= r_op_cnt + CW'(1);
                2'b01:   r_op_cnt <= r_op_cnt - CW'(1);
                default: ;
            endcase

            if (rd_stb && !w_res_empty) begin
                r_half <= ~r_half;
            end
            if (w_store)  r_res_wptr <= r_res_wptr + AW'(1);
            if (w_rd_pop) r_res_rptr <= r_res_rptr + AW'(1);
            unique case ({w_store, w_rd_pop})
                2'b10:   r_res_cnt <= r_res_cnt + CW'(1);
                2'b01:   r_res_cnt <= r_res_cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_copro_batch_sequencer.sv
// Scoreboard bench for copro_batch_sequencer with a registered reference MAC
// (D = A*B + C in signed 9.7, wrapping).
module tb_copro_batch_sequencer;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned MAC_LATENCY = 1;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        clr     = 1'b0;
    logic        wr_stb  = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        rd_stb  = 1'b0;
    logic [7:0]  rd_data;
    logic [7:0]  status;
    logic [15:0] mac_a, mac_b, mac_c, mac_d;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q [$];

    copro_batch_sequencer #(
        .DEPTH       (DEPTH),
        .MAC_LATENCY (MAC_LATENCY)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_stb  (wr_stb),
        .wr_data (wr_data),
        .rd_stb  (rd_stb),
        .rd_data (rd_data),
        .status  (status),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_c   (mac_c),
        .mac_d   (mac_d)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[22:7] + c;
    endfunction

    always_ff @(posedge clk) mac_d <= mac_fn(mac_a, mac_b, mac_c);

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, want);
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_data = b;
        wr_stb  = 1'b1;
        @(posedge clk);
        #1 wr_stb = 1'b0;
    endtask

    task automatic write_triple(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input bit keep);
        if (keep) exp_q.push_back(mac_fn(a, b, c));
        write_byte(a[7:0]);
        write_byte(a[15:8]);
        write_byte(b[7:0]);
        write_byte(b[15:8]);
        write_byte(c[7:0]);
        write_byte(c[15:8]);
    endtask

    task automatic pulse_rd();
        rd_stb = 1'b1;
        @(posedge clk);
        #1 rd_stb = 1'b0;
    endtask

    task automatic read_result(input string tag);
        logic [15:0] e;
        int          waited;
        waited = 0;
        @(negedge clk);
        while (status[4] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (status[4]) begin
            check_eq({tag, "_timeout"}, 16'(status[4]), 16'h0);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, 16'(exp_q.size()), 16'h1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_lo"}, {8'h00, rd_data}, {8'h00, e[7:0]});
        pulse_rd();
        @(negedge clk);
        check_eq({tag, "_hi"}, {8'h00, rd_data}, {8'h00, e[15:8]});
        pulse_rd();
    endtask

    task automatic check_status(input string tag, input logic [7:0] want);
        @(negedge clk);
        check_eq(tag, {8'h00, status}, {8'h00, want});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] ey;
        logic [15:0] ex;

        // Reset values
        #1;
        check_eq("rst_status", {8'h00, status}, 16'h0010);
        check_eq("rst_rd_data", {8'h00, rd_data}, 16'h0000);
        check_eq("rst_mac_a", mac_a, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1.0 * 2.0 + 0.5
        write_triple(16'h0080, 16'h0100, 16'h0040, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t1_status", {8'h00, status}, 16'h0001);
        read_result("t1");
        check_status("t1_status_after", 8'h10);

        // -1.0 * 1.0 + 0
        write_triple(16'hFF80, 16'h0080, 16'h0000, 1'b1);
        read_result("t2");

        // Overflow: 4 results + 4 queued ops kept, 9th dropped
        for (int i = 0; i < 9; i++) begin
            write_triple(16'((i + 1) * 128), 16'h0080, 16'(i), i < 8);
        end
        repeat (10) @(negedge clk);
        check_eq("t3_status_full", {8'h00, status}, 16'h00E4);
        for (int i = 0; i < 8; i++) read_result($sformatf("t3_r%0d", i));
        repeat (10) @(negedge clk);
        check_eq("t3_status_drained", {8'h00, status}, 16'h0090);

        // Partial triple flushed by clr; ovf also cleared
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check_status("t4_status_clr", 8'h10);
        write_triple(16'h0080, 16'h0080, 16'h0000, 1'b1);
        read_result("t4");
        repeat (2) @(negedge clk);
        check_eq("t4_status_end", {8'h00, status}, 16'h0010);

        // Async reset while an op is in WAIT with two more queued
        for (int i = 0; i < 7; i++) begin
            write_triple(16'(16'h0100 + i), 16'h0080, 16'h0001, 1'b1);
        end
        repeat (6) @(negedge clk);
        check_eq("t5_status_pre", {8'h00, status}, 16'h0044);
        read_result("t5_r0");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_status", {8'h00, status}, 16'h0010);
        check_eq("t5_rst_rd_data", {8'h00, rd_data}, 16'h0000);
        check_eq("t5_rst_mac_a", mac_a, 16'h0000);
        check_eq("t5_rst_mac_b", mac_b, 16'h0000);
        check_eq("t5_rst_mac_c", mac_c, 16'h0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t5_status_after", {8'h00, status}, 16'h0010);
        check_eq("t5_rd_data_after", {8'h00, rd_data}, 16'h0000);

        // Read on empty, then final write byte coinciding with a result pop
        @(negedge clk);
        pulse_rd();
        check_status("t6_empty_rd_status", 8'h10);
        check_eq("t6_empty_rd_data", {8'h00, rd_data}, 16'h0000);
        write_triple(16'h0200, 16'hFF00, 16'h0030, 1'b1);
        ey = mac_fn(16'h0180, 16'h0040, 16'hFFF0);
        exp_q.push_back(ey);
        write_byte(8'h80);
        write_byte(8'h01);
        write_byte(8'h40);
        write_byte(8'h00);
        write_byte(8'hF0);
        repeat (4) @(negedge clk);
        ex = exp_q.pop_front();
        check_eq("t6_x_lo", {8'h00, rd_data}, {8'h00, ex[7:0]});
        pulse_rd();
        @(negedge clk);
        check_eq("t6_x_hi", {8'h00, rd_data}, {8'h00, ex[15:8]});
        wr_data = 8'hFF;
        wr_stb  = 1'b1;
        rd_stb  = 1'b1;
        @(posedge clk);
        #1;
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        @(negedge clk);
        check_eq("t6_status_overlap", {8'h00, status}, 16'h0050);
        read_result("t6_y");
        repeat (2) @(negedge clk);
        check_eq("t6_status_end", {8'h00, status}, 16'h0010);
        check_eq("t6_sb_empty", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
